// File: rtl/pq_arb.sv
// Round-robin arbiter sharing one priority-queue device among NREQ requesters.
// Define PQ_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module pq_arb #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ),
   parameter int KV_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_enq,
   input  logic [NREQ-1:0]      req_deq,
   input  logic [NREQ*KV_W-1:0] req_kv,
   output logic [NREQ-1:0]      ack,
   output logic [KV_W-1:0]      rsp_kv,
   output logic                 rsp_err,
   output logic [IDX_W-1:0]     gnt_idx,
   output logic                 pq_enq,
   output logic                 pq_deq,
   output logic [KV_W-1:0]      pq_kvi,
   input  logic [KV_W-1:0]      pq_kvo,
   input  logic                 pq_full,
   input  logic                 pq_empty,
   input  logic                 pq_busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

   state_e           state_q, state_d;
   logic [NREQ-1:0]  pend;
   logic             grant;
   logic [IDX_W-1:0] win;
   logic [IDX_W-1:0] gnt_q;
   logic             deq_q, go_q, err_q;
   logic [KV_W-1:0]  kvi_q, rsp_kv_q;

   assign pend  = req_enq | req_deq;
   assign grant = (state_q == IDLE) && !pq_busy && (|pend);

`ifdef PQ_ARB_FIXED_PRI_EN
   always_comb begin
      win = '0;
      for (int i = NREQ-1; i >= 0; i--)
         if (pend[i]) win = IDX_W'(i);
   end
`else
   logic [IDX_W-1:0] last_q;
   logic [IDX_W-1:0] cand;

   // Walk from the farthest slot inward so the nearest pending after last_q wins.
   always_comb begin
      win  = '0;
      cand = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDX_W'((int'(last_q) + k) % NREQ);
         if (pend[cand]) win = cand;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       last_q <= IDX_W'(NREQ-1);
      else if (grant) last_q <= win;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant) state_d = ISSUE;
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The PQ only changes on our own strobes, so full/empty seen at grant time
   // still hold in ISSUE; deciding early keeps the strobes free of input paths.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q    <= '0;
         deq_q    <= 1'b0;
         go_q     <= 1'b0;
         err_q    <= 1'b0;
         kvi_q    <= '0;
         rsp_kv_q <= '0;
      end else begin
         if (grant) begin
            gnt_q <= win;
            deq_q <= req_deq[win];
            go_q  <= req_deq[win] ? !pq_empty : !pq_full;
            err_q <= req_deq[win] ?  pq_empty :  pq_full;
            kvi_q <= req_kv[win*KV_W +: KV_W];
         end
         if (state_q == ISSUE && deq_q && go_q) rsp_kv_q <= pq_kvo;
      end
   end

   always_comb begin
      ack     = '0;
      pq_enq  = 1'b0;
      pq_deq  = 1'b0;
      rsp_err = 1'b0;
      case (state_q)
         ISSUE: begin
            pq_enq = go_q && !deq_q;
            pq_deq = go_q &&  deq_q;
         end
         RESP: begin
            ack[gnt_q] = 1'b1;
            rsp_err    = err_q;
         end
         default: ;
      endcase
   end

   assign gnt_idx = gnt_q;
   assign pq_kvi  = kvi_q;
   assign rsp_kv  = rsp_kv_q;

endmodule

// File: tb/tb_pq_arb.sv
// Bench for pq_arb: directed op table, hand-written timing/RR/busy/reset sequences,
// then random traffic checked against a transaction-level arbitration model.
module tb_pq_arb;
   localparam int NREQ = 4;
   localparam int KV_W = 16;
   localparam int CAP  = 6;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_enq, req_deq;
   logic [NREQ*KV_W-1:0] req_kv;
   logic [NREQ-1:0]      ack;
   logic [KV_W-1:0]      rsp_kv;
   logic                 rsp_err;
   logic [1:0]           gnt_idx;
   logic                 pq_enq, pq_deq;
   logic [KV_W-1:0]      pq_kvi, pq_kvo;
   logic                 pq_full, pq_empty, pq_busy;

   pq_arb #(.NREQ(NREQ), .KV_W(KV_W)) dut (
      .clk(clk), .rst(rst), .req_enq(req_enq), .req_deq(req_deq), .req_kv(req_kv),
      .ack(ack), .rsp_kv(rsp_kv), .rsp_err(rsp_err), .gnt_idx(gnt_idx),
      .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
      .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy)
   );

   always #5 clk = ~clk;

   // Behavioural PQ: sorted by key (upper byte), smallest key at the head.
   logic [KV_W-1:0] q[$];
   logic [KV_W-1:0] mhead  = '0;
   logic            mempty = 1'b1;
   logic            mfull  = 1'b0;
   int              msize  = 0;
   logic            ffull;

   always @(posedge clk) begin
      int p;
      if (pq_deq && q.size() > 0) void'(q.pop_front());
      if (pq_enq && q.size() < CAP) begin
         p = 0;
         while (p < q.size() && q[p][15:8] <= pq_kvi[15:8]) p++;
         q.insert(p, pq_kvi);
      end
      mhead  <= (q.size() > 0) ? q[0] : '0;
      mempty <= (q.size() == 0);
      mfull  <= (q.size() >= CAP);
      msize  <= q.size();
   end

   assign pq_kvo   = mhead;
   assign pq_empty = mempty;
   assign pq_full  = mfull | ffull;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NREQ-1:0] a);
      int r = -1;
      if ($onehot(a))
         for (int i = 0; i < NREQ; i++) if (a[i]) r = i;
      return r;
   endfunction

   task automatic wait_ack(output int w, output int c);
      w = -1;
      c = 0;
      while (c < 40) begin
         @(negedge clk);
         c++;
         if (ack != '0) begin
            w = onehot_idx(ack);
            return;
         end
      end
   endtask

   // Post one op, wait for its ack, drop the request, land in the next IDLE cycle.
   task automatic do_op(input int rq, input bit e, input bit d, input logic [15:0] kv,
                        output int w, output int c, output logic [15:0] rkv,
                        output logic rerr, output int g);
      req_enq[rq] = e;
      req_deq[rq] = d;
      req_kv[rq*KV_W +: KV_W] = kv;
      wait_ack(w, c);
      rkv  = rsp_kv;
      rerr = rsp_err;
      g    = int'(gnt_idx);
      req_enq[rq] = 1'b0;
      req_deq[rq] = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      int          rq;
      bit          enq, deq, ff;
      logic [15:0] kv;
      bit          err;
      logic [15:0] xkv;
      int          size;
   } vec_t;

   typedef struct {
      logic [NREQ-1:0] enq, deq;
      logic            busy, full, empty;
      logic [15:0]     head;
      int              size;
   } snap_t;

   vec_t        tbl[11];
   snap_t       hist[4];
   int          w, c, g, ew, last_w, seen, exp_size;
   logic [15:0] rkv, exp_rsp;
   logic        rerr, edeq, eerr;

   initial begin
      tbl[0]  = '{0, 1, 0, 0, 16'h0511, 0, 16'h0000, 1};
      tbl[1]  = '{0, 0, 1, 0, 16'h0000, 0, 16'h0511, 0};
      tbl[2]  = '{3, 0, 1, 0, 16'h0000, 1, 16'h0511, 0};
      tbl[3]  = '{2, 1, 0, 0, 16'h0322, 0, 16'h0511, 1};
      tbl[4]  = '{1, 1, 1, 0, 16'h0933, 0, 16'h0322, 0};
      tbl[5]  = '{1, 0, 1, 0, 16'h0000, 1, 16'h0322, 0};
      tbl[6]  = '{2, 1, 0, 1, 16'h0744, 1, 16'h0322, 0};
      tbl[7]  = '{3, 1, 0, 0, 16'h0255, 0, 16'h0322, 1};
      tbl[8]  = '{0, 1, 0, 0, 16'h0166, 0, 16'h0322, 2};
      tbl[9]  = '{1, 0, 1, 0, 16'h0000, 0, 16'h0166, 1};
      tbl[10] = '{2, 0, 1, 0, 16'h0000, 0, 16'h0255, 0};

      rst = 1'b0; req_enq = '0; req_deq = '0; req_kv = '0; pq_busy = 1'b0; ffull = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {ack, pq_enq, pq_deq, rsp_err, rsp_kv, pq_kvi, gnt_idx}, 64'h0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         ffull = tbl[i].ff;
         do_op(tbl[i].rq, tbl[i].enq, tbl[i].deq, tbl[i].kv, w, c, rkv, rerr, g);
         ffull = 1'b0;
         chk($sformatf("vec%0d_ack", i), w, tbl[i].rq);
         chk($sformatf("vec%0d_gnt", i), g, tbl[i].rq);
         chk($sformatf("vec%0d_err", i), rerr, tbl[i].err);
         chk($sformatf("vec%0d_kv", i), rkv, tbl[i].xkv);
         chk($sformatf("vec%0d_size", i), msize, tbl[i].size);
         chk($sformatf("vec%0d_idle", i), {ack, rsp_err}, 0);
      end

      // Single-op timing: strobe one cycle after the grant edge, ack one after that.
      req_enq[0] = 1'b1; req_kv[15:0] = 16'h0a01;
      @(negedge clk);
      chk("tim_strobe", {pq_enq, pq_deq, ack}, {2'b10, 4'b0000});
      chk("tim_kvi", pq_kvi, 16'h0a01);
      @(negedge clk);
      chk("tim_ack", {pq_enq, ack, rsp_err}, {1'b0, 4'b0001, 1'b0});
      req_enq[0] = 1'b0;
      @(negedge clk);
      do_op(0, 0, 1, 16'h0, w, c, rkv, rerr, g);
      chk("tim_deq_kv", rkv, 16'h0a01);
      chk("tim_empty", pq_empty, 1'b1);

      // Busy PQ stalls the grant.
      pq_busy = 1'b1;
      req_enq[1] = 1'b1; req_kv[31:16] = 16'h0777;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if ({pq_enq, pq_deq, ack} != '0) seen++;
      end
      chk("busy_stall", seen, 0);
      pq_busy = 1'b0;
      wait_ack(w, c);
      chk("busy_ack", w, 1);
      chk("busy_lat", c, 2);
      req_enq[1] = 1'b0;
      @(negedge clk);
      chk("busy_size", msize, 1);
      do_op(1, 0, 1, 16'h0, w, c, rkv, rerr, g);
      chk("busy_deq_kv", rkv, 16'h0777);

      // Reset during ISSUE aborts the op.
      req_enq[0] = 1'b1; req_kv[15:0] = 16'h0888;
      @(negedge clk);
      chk("rst_pre_strobe", pq_enq, 1'b1);
      #1 rst = 1'b0;
      #1 chk("rst_async_outs", {ack, pq_enq, pq_deq, rsp_err, rsp_kv, pq_kvi, gnt_idx}, 64'h0);
      req_enq[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack != '0) seen++;
      end
      chk("rst_no_ack", seen, 0);
      chk("rst_no_enq", msize, 0);

`ifndef PQ_ARB_FIXED_PRI_EN
      // Round-robin from reset: 0,1,2 then 0,2 (wraps past last winner 2).
      req_enq = 4'b0111;
      req_kv  = {16'h0, 16'h1202, 16'h1101, 16'h1000};
      for (int i = 0; i < 3; i++) begin
         wait_ack(w, c);
         chk($sformatf("rr1_win%0d", i), w, i);
         chk($sformatf("rr1_gnt%0d", i), gnt_idx, i);
         chk($sformatf("rr1_gap%0d", i), c, (i == 0) ? 2 : 3);
         if (w >= 0) req_enq[w] = 1'b0;
      end
      @(negedge clk);
      req_enq = 4'b0101;
      req_kv  = {16'h0, 16'h1404, 16'h0, 16'h1303};
      wait_ack(w, c);
      chk("rr2_first", w, 0);
      if (w >= 0) req_enq[w] = 1'b0;
      wait_ack(w, c);
      chk("rr2_second", w, 2);
      if (w >= 0) req_enq[w] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         do_op(3, 0, 1, 16'h0, w, c, rkv, rerr, g);
         chk($sformatf("rr_drain%0d", i), rkv, 16'h1000 + 16'(i * 16'h0101));
      end
`else
      // Fixed priority: held req0 wins every grant, req2 waits until req0 drops.
      req_deq[0] = 1'b1;
      req_enq[2] = 1'b1; req_kv[47:32] = 16'h1202;
      for (int i = 0; i < 3; i++) begin
         wait_ack(w, c);
         chk($sformatf("fp_win%0d", i), w, 0);
         chk($sformatf("fp_gap%0d", i), c, (i == 0) ? 2 : 3);
      end
      req_deq[0] = 1'b0;
      wait_ack(w, c);
      chk("fp_starved", w, 2);
      chk("fp_gap_last", c, 3);
      req_enq[2] = 1'b0;
      @(negedge clk);
      do_op(3, 0, 1, 16'h0, w, c, rkv, rerr, g);
      chk("fp_drain", rkv, 16'h1202);
`endif

      // Random traffic against a transaction-level model.
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      last_w  = NREQ - 1;
      exp_rsp = '0;
      for (int i = 0; i < 4; i++) hist[i] = '{'0, '0, 1'b0, 1'b0, 1'b1, '0, 0};
      for (int cyc = 0; cyc < 900; cyc++) begin
         snap_t s;
         @(negedge clk);
         w = -1;
         if (ack != '0) begin
            s  = hist[(cyc + 2) % 4];
            ew = -1;
`ifdef PQ_ARB_FIXED_PRI_EN
            for (int k = NREQ - 1; k >= 0; k--)
               if (s.enq[k] | s.deq[k]) ew = k;
`else
            for (int k = NREQ; k >= 1; k--)
               if (s.enq[(last_w + k) % NREQ] | s.deq[(last_w + k) % NREQ]) ew = (last_w + k) % NREQ;
`endif
            w = onehot_idx(ack);
            chk("rnd_win", w, ew);
            chk("rnd_gnt", gnt_idx, ew);
            chk("rnd_not_busy", s.busy, 1'b0);
            if (ew >= 0) begin
               edeq = s.deq[ew];
               eerr = edeq ? s.empty : s.full;
               if (edeq && !eerr) exp_rsp = s.head;
               exp_size = s.size + (eerr ? 0 : (edeq ? -1 : 1));
               chk("rnd_err", rsp_err, eerr);
               chk("rnd_kv", rsp_kv, exp_rsp);
               chk("rnd_size", msize, exp_size);
               last_w = ew;
            end
            if (w >= 0) begin
               req_enq[w] = 1'b0;
               req_deq[w] = 1'b0;
            end
         end
         if (pq_enq | pq_deq) chk("rnd_excl", pq_enq & pq_deq, 1'b0);
         if (cyc < 800) begin
            for (int r = 0; r < NREQ; r++) begin
               if (r != w && !(req_enq[r] | req_deq[r]) && $urandom_range(2) == 0) begin
                  case ($urandom_range(3))
                     0, 1: req_enq[r] = 1'b1;
                     2:    req_deq[r] = 1'b1;
                     default: begin req_enq[r] = 1'b1; req_deq[r] = 1'b1; end
                  endcase
                  req_kv[r*KV_W +: KV_W] = 16'($urandom);
               end
            end
            pq_busy = ($urandom_range(5) == 0);
         end else begin
            pq_busy = 1'b0;
         end
         hist[cyc % 4] = '{req_enq, req_deq, pq_busy, pq_full, pq_empty, pq_kvo, msize};
      end
      chk("rnd_drained", req_enq | req_deq, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
